// File: rtl/instr_sequencer.sv
// Multicycle FETCH/PREP/EXEC/IDLE sequencer with instruction register,
// one-hot opcode decode, run/step control, halt detect and retire counter.
module instr_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             ld_ir,
    input  logic             sm_en,
    input  logic [7:0]       ram_dout,
    output logic [1:0]       sm,
    output logic [7:0]       ir,
    output logic             mova,
    output logic             movb,
    output logic             movc,
    output logic             movd,
    output logic             add,
    output logic             sub,
    output logic             jmp,
    output logic             jg,
    output logic             in1,
    output logic             out1,
    output logic             movi,
    output logic             halt,
    output logic             illegal,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_PREP  = 2'b01,
        S_EXEC  = 2'b10,
        S_IDLE  = 2'b11
    } state_t;

    state_t           r_sm;
    state_t           w_sm_nxt;
    logic [7:0]       r_ir;
    logic             r_ir_valid;
    logic             r_step_pend;
    logic [CNT_W-1:0] r_icount;
    logic             w_go;
    logic             w_start;
    logic             w_halted;
    logic [11:0]      w_dec;
    logic             w_ill;

    assign w_go    = run | r_step_pend;
    assign w_start = (r_sm == S_IDLE) & sm_en & w_go;

    // Next-state selection; every move waits for the controller's sm_en.
    always_comb begin
        w_sm_nxt = r_sm;
        if (sm_en) begin
            unique case (r_sm)
                S_IDLE:  w_sm_nxt = w_go ? S_FETCH : S_IDLE;
                S_FETCH: w_sm_nxt = S_PREP;
                S_PREP:  w_sm_nxt = S_EXEC;
                S_EXEC:  w_sm_nxt = run ? S_FETCH : S_IDLE;
            endcase
        end
    end

    // State register, instruction register, step latch and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sm        <= S_IDLE;
            r_ir        <= 8'h00;
            r_ir_valid  <= 1'b0;
            r_step_pend <= 1'b0;
            r_icount    <= '0;
        end else begin
            r_sm <= w_sm_nxt;
            if (ld_ir && r_sm == S_FETCH) begin
                r_ir       <= ram_dout;
                r_ir_valid <= 1'b1;
            end
            if (w_start)
                r_step_pend <= 1'b0;
            else if (step && !run && !w_halted)
                r_step_pend <= 1'b1;
            if (r_sm == S_EXEC && sm_en)
                r_icount <= r_icount + 1'b1;
        end
    end

    // One-hot opcode decode; unassigned codes flag illegal and act as NOP.
    always_comb begin
        w_dec = 12'h000;
        w_ill = 1'b0;
        if (r_ir_valid) begin
            case (r_ir[7:4])
                4'b1111: w_dec = 12'h800;
                4'b1101: w_dec = 12'h400;
                4'b1100: w_dec = 12'h200;
                4'b1010: w_dec = 12'h100;
                4'b1001: w_dec = 12'h080;
                4'b0110: w_dec = 12'h040;
                4'b0000: w_dec = 12'h020;
                4'b0001: w_dec = 12'h010;
                4'b0010: w_dec = 12'h008;
                4'b0100: w_dec = 12'h004;
                4'b0111: w_dec = 12'h002;
                4'b1000: w_dec = 12'h001;
                default: w_ill = 1'b1;
            endcase
        end
    end

    assign {mova, movb, movc, movd, add, sub,
            jmp, jg, in1, out1, movi, halt} = w_dec;

    assign w_halted = (r_sm == S_EXEC) & halt & ~sm_en;
    assign halted   = w_halted;
    assign illegal  = w_ill;
    assign busy     = (r_sm != S_IDLE);
    assign sm       = r_sm;
    assign ir       = r_ir;
    assign icount   = r_icount;

endmodule
